memory_bus_unit: RTL and testbench
==================================

// Module: memory_bus_unit
// PURPOSE
// Next-generation load/store unit: executes byte/half/word(/double) accesses over a req/ack memory bus instead of
// simulator callbacks. Parametrised data width, optional hardware splitting of misaligned accesses into two bus
// beats, bus-error and timeout detection. Sits between execute stage and memory bus; same op/fault semantics as core.
// PARAMETERS
// XLEN             32   data/bus width, 32 or 64; BYTES = XLEN/8
// ALLOW_MISALIGNED 0    1: split/serve misaligned accesses; 0: raise addr_fault
// TIMEOUT_CYCLES   15   max cycles bus_req waits for ack/err before access_fault; 0 disables timeout
// PORTS
// clk           in   1       clock
// reset_n       in   1       reset, synchronous, active low
// available     in   1       operation request; held high (inputs stable) until done
// is_write      in   1       1=store, 0=load
// is_unsigned   in   1       load zero-extends (else sign-extends)
// op            in   2       00=byte 01=half 10=word 11=double (XLEN=64 only)
// addr          in   32      byte address
// in            in   XLEN    store data (LSB-aligned)
// out           out  XLEN    load result, valid with done, held until next accept
// busy          out  1       operation in progress
// done          out  1       one-cycle completion pulse; faults/out valid this cycle
// op_fault      out  1       invalid op
// addr_fault    out  1       misaligned, ALLOW_MISALIGNED=0
// access_fault  out  1       bus_err or timeout
// bus_req       out  1       bus request, held until ack/err/timeout
// bus_we        out  1       bus write
// bus_addr      out  32      BYTES-aligned address
// bus_be        out  BYTES   byte enables
// bus_wdata     out  XLEN    lane-positioned store data
// bus_ack       in   1       beat complete; bus_rdata valid same cycle
// bus_err       in   1       beat failed
// bus_rdata     in   XLEN    read data
// BEHAVIOUR
// - Reset (reset_n low at clk edge): state IDLE; all outputs 0; pending ack/err ignored; takes effect mid-op.
// - FSM IDLE -> BEAT0 -> [BEAT1] -> IDLE. Accept when IDLE & available & ~done.
// - Accept decode: op 11 with XLEN=32 -> op_fault; size>BYTES never. Misaligned = addr % size != 0.
//   Fault at accept (op_fault or addr_fault): no bus traffic; done=1 next cycle with flag set; busy stays 0.
// - Otherwise busy=1 next cycle with bus_req=1; off=addr%BYTES; bus_addr=addr&~(BYTES-1);
//   bus_be=mask(size)<<off truncated to BYTES; bus_wdata=in<<(8*off).
// - Beat ends on the edge where bus_req & (bus_ack|bus_err), or wait count reaches TIMEOUT_CYCLES;
//   bus_req drops that edge. ack&err together = err. Counter resets per beat.
// - Split: off+size > BYTES (ALLOW_MISALIGNED=1 only) -> BEAT1 at bus_addr+BYTES, bus_be=mask>>(BYTES-off),
//   bus_wdata=in>>(8*(BYTES-off)); bus_req deasserts one cycle between beats. Error on BEAT0 skips BEAT1
//   (store may be partially written; not rolled back).
// - Completion: busy=0, done=1 for one cycle; out = lanes collected, shifted to LSB, sign/zero extended from
//   size (writes: out=0). access_fault/out hold until next accept; done clears after one cycle.
// - Latency (ack same cycle as req): aligned 2 cycles accept->done; split 4 cycles; fault 1 cycle.
// - available dropping while busy is illegal; behaviour undefined except reset recovers.
// TESTING
// 1. XLEN=32 byte load addr 0x1003, ack rdata 0x80112233, signed -> bus_be 1000, out 0xFFFFFF80; unsigned -> 0x80.
// 2. Half store addr 0x2002, in 0x0000BEEF -> bus_addr 0x2000, bus_be 1100, bus_wdata 0xBEEF0000, done, no faults.
// 3. ALLOW_MISALIGNED=0 word load addr 0x3 -> addr_fault with done 1 cycle later, bus_req never asserted.
// 4. ALLOW_MISALIGNED=1 word load addr 0x3: beat0 0x0 be 1000 rdata 0xAA000000, beat1 0x4 be 0111
//    rdata 0x00DDCCBB -> out 0xDDCCBBAA.
// 5. TIMEOUT_CYCLES=15, no ack -> bus_req drops after 15 cycles, access_fault=1 with done; op 11 XLEN=32 -> op_fault.
// 6. reset_n low while bus_req high, then late bus_ack -> all outputs 0, no done; next op completes normally.

Source files
------------

// File: rtl/memory_bus_unit_if.sv
// Request/response and memory-bus signal bundle for memory_bus_unit.
// The master modport is the load/store unit; slave is the execute stage plus memory.
interface memory_bus_unit_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned BYTES = XLEN / 8;

  logic             available;
  logic             is_write;
  logic             is_unsigned;
  logic [1:0]       op;
  logic [31:0]      addr;
  logic [XLEN-1:0]  in;
  logic [XLEN-1:0]  out;
  logic             busy;
  logic             done;
  logic             op_fault;
  logic             addr_fault;
  logic             access_fault;
  logic             bus_req;
  logic             bus_we;
  logic [31:0]      bus_addr;
  logic [BYTES-1:0] bus_be;
  logic [XLEN-1:0]  bus_wdata;
  logic             bus_ack;
  logic             bus_err;
  logic [XLEN-1:0]  bus_rdata;

  modport master (
    input  available, is_write, is_unsigned, op, addr, in, bus_ack, bus_err, bus_rdata,
    output out, busy, done, op_fault, addr_fault, access_fault,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output available, is_write, is_unsigned, op, addr, in, bus_ack, bus_err, bus_rdata,
    input  out, busy, done, op_fault, addr_fault, access_fault,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/memory_bus_unit.sv
// Load/store unit driving a req/ack memory bus: lane positioning, optional misaligned
// splitting into two beats, sign/zero extension, bus-error and timeout faults.
module memory_bus_unit #(
  parameter int unsigned XLEN             = 32,
  parameter bit          ALLOW_MISALIGNED = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES   = 15
) (
  input logic               clk,
  input logic               reset_n,
  memory_bus_unit_if.master bus_if
);
  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OffW  = $clog2(BYTES);
  localparam int unsigned MaskW = 2 * BYTES;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {StIdle, StBeat0, StGap, StBeat1} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            op_fault_q, op_fault_d;
  logic            addr_fault_q, addr_fault_d;
  logic            access_fault_q, access_fault_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            we_q, we_d;
  logic            uns_q, uns_d;
  logic            split_q, split_d;
  logic [3:0]      size_q, size_d;
  logic [31:0]     addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] acc_q, acc_d;

  logic [3:0]      req_size;
  logic [OffW-1:0] req_off;
  logic            req_op_bad, req_misal, req_split, accept;

  always_comb begin
    case (bus_if.op)
      2'b00:   req_size = 4'd1;
      2'b01:   req_size = 4'd2;
      2'b10:   req_size = 4'd4;
      default: req_size = 4'd8;
    endcase
    req_off    = bus_if.addr[OffW-1:0];
    req_op_bad = (bus_if.op == 2'b11) && (XLEN != 64);
    req_misal  = (bus_if.addr[3:0] & (req_size - 4'd1)) != 4'd0;
    req_split  = ({1'b0, 4'(req_off)} + {1'b0, req_size}) > 5'(BYTES);
    accept     = (state_q == StIdle) && bus_if.available && !done_q;
  end

  logic [OffW-1:0]  off;
  logic [MaskW-1:0] mask_w;
  logic [BYTES-1:0] be0, be1;
  logic [XLEN-1:0]  wd0, wd1, rd0, rd1;
  logic [XLEN-1:0]  fin_data, keep, sign_src, fin_ext;
  logic             timeout;

  // Beat 0 carries the low bytes at lane off; beat 1 carries the remainder at lane 0.
  always_comb begin
    off      = addr_q[OffW-1:0];
    mask_w   = MaskW'((32'd1 << size_q) - 32'd1);
    be0      = BYTES'(mask_w << off);
    be1      = BYTES'(mask_w >> (BYTES - 32'(off)));
    wd0      = wdata_q << (8 * off);
    wd1      = wdata_q >> (8 * (BYTES - 32'(off)));
    rd0      = bus_if.bus_rdata >> (8 * off);
    rd1      = bus_if.bus_rdata << (8 * (BYTES - 32'(off)));
    fin_data = (state_q == StBeat1) ? (acc_q | rd1) : rd0;
    keep     = (32'(size_q) >= BYTES) ? '1 : ((XLEN'(1) << (8 * size_q)) - XLEN'(1));
    sign_src = fin_data >> (8 * size_q - 1);
    fin_ext  = (fin_data & keep) | ((!uns_q && sign_src[0]) ? ~keep : '0);
    timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      op_fault_q     <= 1'b0;
      addr_fault_q   <= 1'b0;
      access_fault_q <= 1'b0;
      out_q          <= '0;
      we_q           <= 1'b0;
      uns_q          <= 1'b0;
      split_q        <= 1'b0;
      size_q         <= 4'd1;
      addr_q         <= '0;
      wdata_q        <= '0;
      acc_q          <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      op_fault_q     <= op_fault_d;
      addr_fault_q   <= addr_fault_d;
      access_fault_q <= access_fault_d;
      out_q          <= out_d;
      we_q           <= we_d;
      uns_q          <= uns_d;
      split_q        <= split_d;
      size_q         <= size_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      acc_q          <= acc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    op_fault_d     = op_fault_q;
    addr_fault_d   = addr_fault_q;
    access_fault_d = access_fault_q;
    out_d          = out_q;
    we_d           = we_q;
    uns_d          = uns_q;
    split_d        = split_q;
    size_d         = size_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    acc_d          = acc_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          we_d           = bus_if.is_write;
          uns_d          = bus_if.is_unsigned;
          size_d         = req_size;
          addr_d         = bus_if.addr;
          wdata_d        = bus_if.in;
          split_d        = req_split;
          acc_d          = '0;
          cnt_d          = '0;
          out_d          = '0;
          op_fault_d     = req_op_bad;
          addr_fault_d   = !req_op_bad && req_misal && !ALLOW_MISALIGNED;
          access_fault_d = 1'b0;
          if (op_fault_d || addr_fault_d) begin
            done_d = 1'b1;
          end else begin
            state_d = StBeat0;
          end
        end
      end
      StBeat0, StBeat1: begin
        // err wins over a simultaneous ack; an error on beat 0 skips beat 1
        if (bus_if.bus_err || (timeout && !bus_if.bus_ack)) begin
          access_fault_d = 1'b1;
          out_d          = '0;
          done_d         = 1'b1;
          state_d        = StIdle;
        end else if (bus_if.bus_ack) begin
          if (state_q == StBeat0 && split_q) begin
            acc_d   = rd0;
            state_d = StGap;
          end else begin
            out_d   = we_q ? '0 : fin_ext;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        cnt_d   = '0;
        state_d = StBeat1;
      end
      default: state_d = StIdle;
    endcase
  end

  logic beat_req, beat_hi;
  always_comb begin
    beat_req             = (state_q == StBeat0) || (state_q == StBeat1);
    beat_hi              = (state_q == StBeat1);
    bus_if.busy          = (state_q != StIdle);
    bus_if.bus_req       = beat_req;
    bus_if.bus_we        = beat_req && we_q;
    bus_if.bus_addr      = '0;
    bus_if.bus_be        = '0;
    bus_if.bus_wdata     = '0;
    if (beat_req) begin
      bus_if.bus_addr  = (addr_q & ~(32'(BYTES) - 32'd1)) + (beat_hi ? 32'(BYTES) : 32'd0);
      bus_if.bus_be    = beat_hi ? be1 : be0;
      bus_if.bus_wdata = beat_hi ? wd1 : wd0;
    end
    bus_if.done          = done_q;
    bus_if.out           = out_q;
    bus_if.op_fault      = op_fault_q;
    bus_if.addr_fault    = addr_fault_q;
    bus_if.access_fault  = access_fault_q;
  end
endmodule

// File: tb/tb_memory_bus_unit.sv
// Directed bench: instance A rejects misaligned accesses, instance B splits them.
module tb_memory_bus_unit;
  logic clk = 1'b0;
  logic reset_n;
  logic avail_a, avail_b, is_write, is_unsigned, bus_ack, bus_err;
  logic [1:0]  op;
  logic [31:0] addr, din, bus_rdata;
  int checks = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  memory_bus_unit_if #(.XLEN(32)) ifa ();
  memory_bus_unit_if #(.XLEN(32)) ifb ();

  assign ifa.available   = avail_a;
  assign ifb.available   = avail_b;
  assign ifa.is_write    = is_write;
  assign ifb.is_write    = is_write;
  assign ifa.is_unsigned = is_unsigned;
  assign ifb.is_unsigned = is_unsigned;
  assign ifa.op          = op;
  assign ifb.op          = op;
  assign ifa.addr        = addr;
  assign ifb.addr        = addr;
  assign ifa.in          = din;
  assign ifb.in          = din;
  assign ifa.bus_ack     = bus_ack;
  assign ifb.bus_ack     = bus_ack;
  assign ifa.bus_err     = bus_err;
  assign ifb.bus_err     = bus_err;
  assign ifa.bus_rdata   = bus_rdata;
  assign ifb.bus_rdata   = bus_rdata;

  memory_bus_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0), .TIMEOUT_CYCLES(15)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_if  (ifa)
  );

  memory_bus_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1), .TIMEOUT_CYCLES(15)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_if  (ifb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic we, input logic uns, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] d);
    is_write = we; is_unsigned = uns; op = o; addr = a; din = d;
  endtask

  // One aligned access on instance A with an ack in the first request cycle.
  task automatic beat_a(input string tag, input logic [31:0] rdata, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_out);
    avail_a = 1'b1;
    @(negedge clk);
    check({tag, "_req"},   ifa.bus_req, 1'b1);
    check({tag, "_busy"},  ifa.busy, 1'b1);
    check({tag, "_we"},    ifa.bus_we, is_write);
    check({tag, "_baddr"}, ifa.bus_addr, e_addr);
    check({tag, "_be"},    ifa.bus_be, e_be);
    if (is_write) check({tag, "_wdata"}, ifa.bus_wdata, e_wdata);
    bus_ack = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    bus_ack = 1'b0; avail_a = 1'b0;
    check({tag, "_done"},  ifa.done, 1'b1);
    check({tag, "_reqlo"}, ifa.bus_req, 1'b0);
    check({tag, "_out"},   ifa.out, e_out);
    check({tag, "_flt"},   {ifa.op_fault, ifa.addr_fault, ifa.access_fault}, 3'b000);
    @(negedge clk);
    check({tag, "_done1"}, ifa.done, 1'b0);
    check({tag, "_hold"},  ifa.out, e_out);
  endtask

  initial begin
    reset_n = 1'b0; avail_a = 1'b0; avail_b = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    bus_rdata = '0;
    set_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("rst_a", {ifa.busy, ifa.done, ifa.bus_req, ifa.op_fault, ifa.addr_fault,
                    ifa.access_fault}, 6'b0);
    check("rst_out", ifa.out, 32'h0);
    check("rst_b", {ifb.busy, ifb.done, ifb.bus_req}, 3'b0);
    reset_n = 1'b1;
    @(negedge clk);

    set_op(1'b0, 1'b0, 2'b00, 32'h1003, 32'h0);
    beat_a("ldb_s", 32'h80112233, 32'h1000, 4'b1000, 32'h0, 32'hFFFFFF80);
    set_op(1'b0, 1'b1, 2'b00, 32'h1003, 32'h0);
    beat_a("ldb_u", 32'h80112233, 32'h1000, 4'b1000, 32'h0, 32'h00000080);
    set_op(1'b1, 1'b0, 2'b01, 32'h2002, 32'h0000BEEF);
    beat_a("sth", 32'h0, 32'h2000, 4'b1100, 32'hBEEF0000, 32'h0);
    set_op(1'b0, 1'b0, 2'b01, 32'h0002, 32'h0);
    beat_a("ldh_s", 32'h80015555, 32'h0000, 4'b1100, 32'h0, 32'hFFFF8001);

    // Misaligned word on A faults without bus traffic.
    set_op(1'b0, 1'b0, 2'b10, 32'h3, 32'h0);
    avail_a = 1'b1;
    @(negedge clk);
    avail_a = 1'b0;
    check("misal_done", ifa.done, 1'b1);
    check("misal_af",   ifa.addr_fault, 1'b1);
    check("misal_nreq", {ifa.bus_req, ifa.busy}, 2'b00);
    @(negedge clk);
    check("misal_done1", ifa.done, 1'b0);
    check("misal_hold",  {ifa.addr_fault, ifa.bus_req}, 2'b10);

    // Same access on B splits into two beats with a one-cycle gap.
    avail_b = 1'b1;
    @(negedge clk);
    check("sp_b0_req", ifb.bus_req, 1'b1);
    check("sp_b0_ad",  ifb.bus_addr, 32'h0);
    check("sp_b0_be",  ifb.bus_be, 4'b1000);
    bus_ack = 1'b1; bus_rdata = 32'hAA000000;
    @(negedge clk);
    bus_ack = 1'b0;
    check("sp_gap", {ifb.bus_req, ifb.busy, ifb.done}, 3'b010);
    @(negedge clk);
    check("sp_b1_req", ifb.bus_req, 1'b1);
    check("sp_b1_ad",  ifb.bus_addr, 32'h4);
    check("sp_b1_be",  ifb.bus_be, 4'b0111);
    bus_ack = 1'b1; bus_rdata = 32'h00DDCCBB;
    @(negedge clk);
    bus_ack = 1'b0; avail_b = 1'b0;
    check("sp_done", ifb.done, 1'b1);
    check("sp_out",  ifb.out, 32'hDDCCBBAA);
    check("sp_flt",  {ifb.addr_fault, ifb.access_fault}, 2'b00);
    @(negedge clk);

    // Timeout: no ack for a word load.
    set_op(1'b0, 1'b0, 2'b10, 32'h10, 32'h0);
    avail_a = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (ifa.bus_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    avail_a = 1'b0;
    check("to_cycles", cnt, 15);
    check("to_done",   ifa.done, 1'b1);
    check("to_acc",    ifa.access_fault, 1'b1);
    @(negedge clk);
    check("to_hold", {ifa.done, ifa.access_fault}, 2'b01);

    // Simultaneous ack and err counts as an error.
    set_op(1'b0, 1'b0, 2'b10, 32'h20, 32'h0);
    avail_a = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_ack = 1'b0; bus_err = 1'b0; avail_a = 1'b0;
    check("err_done", ifa.done, 1'b1);
    check("err_acc",  ifa.access_fault, 1'b1);
    check("err_out",  ifa.out, 32'h0);
    @(negedge clk);

    // Invalid op with XLEN=32.
    set_op(1'b0, 1'b0, 2'b11, 32'h0, 32'h0);
    avail_a = 1'b1;
    @(negedge clk);
    avail_a = 1'b0;
    check("opf", {ifa.done, ifa.op_fault, ifa.addr_fault, ifa.access_fault, ifa.bus_req},
          5'b11000);
    @(negedge clk);

    // Reset mid-access, then a stale ack.
    set_op(1'b0, 1'b0, 2'b10, 32'h30, 32'h0);
    avail_a = 1'b1;
    @(negedge clk);
    check("rm_req", ifa.bus_req, 1'b1);
    reset_n = 1'b0; avail_a = 1'b0;
    @(negedge clk);
    check("rm_zero", {ifa.busy, ifa.done, ifa.bus_req, ifa.bus_we, ifa.access_fault}, 5'b0);
    check("rm_bus",  {ifa.bus_addr, ifa.bus_be, ifa.out}, 68'h0);
    reset_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_ack = 1'b0;
    check("rm_late", {ifa.busy, ifa.done, ifa.bus_req}, 3'b000);
    check("rm_lout", ifa.out, 32'h0);
    set_op(1'b0, 1'b0, 2'b10, 32'h40, 32'h0);
    beat_a("rm_next", 32'h12345678, 32'h40, 4'b1111, 32'h0, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
